trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Sequences machine-mode trap entry (exceptions and interrupts) and trap exit (mret) for the pipelined core.
- Is the single arbiter of the CSR file write port: muxes pipeline CSR-instruction writes with its own multi-cycle write sequences to mepc, mcause and mstatus.
- Drives pipeline flush/stall and the PC redirect to the trap vector or mepc.

Parameters:
- XLEN, 32, data/PC width.
- CSR_AW, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- exc_valid  in  1  execute-stage exception (level, sampled in IDLE)
- exc_cause  in  4  exception code (2 illegal, 3 ebreak, 11 ecall)
- mret_valid  in  1  mret in execute stage
- pc_in  in  XLEN  PC of execute-stage instruction
- irq_ext, irq_timer, irq_sw  in  1 each  level interrupt lines
- mstatus_q, mie_q, mtvec_q, mepc_q  in  XLEN each  current CSR values from CSR file
- pipe_csr_we  in  1  pipeline CSR write request
- pipe_csr_addr  in  CSR_AW  pipeline CSR address
- pipe_csr_wdata  in  XLEN  pipeline CSR write data
- csr_we  out  1  CSR file write enable
- csr_waddr  out  CSR_AW  CSR file write address
- csr_wdata  out  XLEN  CSR file write data
- mip_o  out  XLEN  pending-interrupt vector to CSR file
- flush_o  out  1  flush IF/ID/EX
- stall_o  out  1  freeze PC and pipeline registers
- redirect_valid  out  1  one-cycle PC redirect strobe
- redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset: FSM to IDLE; all registered state zero; csr_we, flush_o, stall_o, redirect_valid = 0; redirect_pc = 0. Reset mid-sequence abandons it; partial CSR writes are not undone.
- mip_o (combinational): bit 11 = irq_ext, bit 7 = irq_timer, bit 3 = irq_sw; all other bits 0.
- An interrupt is taken when mstatus_q[3] (MIE) = 1 and the matching mie_q bit = 1 and the line is high.
- Priority, evaluated in IDLE only: exc_valid > interrupt (ext cause 11 > sw cause 3 > timer cause 7) > mret_valid.
- On a taken event:
  - Latch pc_in, the cause and an interrupt flag.
  - Compute mcause: interrupt = {1'b1, 27'b0, code}; exception = {28'b0, exc_cause}.
  - Compute target: base = {mtvec_q[31:2], 2'b00}; if mtvec_q[1:0] = 01 and interrupt, base + (code << 2); else base. Sum wraps mod 2^XLEN.
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTAT, REDIR, R_MSTAT, R_REDIR.
- Trap path: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTAT -> REDIR -> IDLE.
  - W_MEPC: csr_we = 1, addr 0x341, data = latched pc with bits [1:0] forced 0.
  - W_MCAUSE: csr_we = 1, addr 0x342, data = latched mcause.
  - W_MSTAT: csr_we = 1, addr 0x300, data = mstatus_q with MPIE(7) = MIE(3), MIE = 0, MPP[12:11] = 11.
- mret path: IDLE -> R_MSTAT -> R_REDIR -> IDLE.
  - R_MSTAT: csr_we = 1, addr 0x300, data = mstatus_q with MIE = MPIE, MPIE = 1, MPP = 11.
  - Target = mepc_q, sampled in R_REDIR.
- REDIR / R_REDIR: redirect_valid = 1 for exactly one cycle with redirect_pc = target; csr_we = 0.
- Latency: trap detected at cycle T gives redirect at T+4; mret at T gives redirect at T+2.
- flush_o and stall_o:
  - Both are combinational.
  - Both are high in the detection cycle and in every non-IDLE state.
  - Both are low in the IDLE cycle after redirect.
- CSR port arbitration:
  - In IDLE with no event taken, csr_we/waddr/wdata = pipe_csr_* (combinational pass-through).
  - In the detection cycle and all non-IDLE states, the controller owns the port and pipe_csr_we is dropped; that instruction is flushed.
- All event inputs are ignored outside IDLE. exc_valid together with mret_valid resolves to the exception.
- Events are re-evaluated in the IDLE cycle after redirect.
  - A level irq that is still high does not re-trap, because mstatus_q.MIE is now 0.
  - After mret, a pending irq may trap immediately, one cycle after R_REDIR.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, FSM IDLE; assert rst during W_MCAUSE -> next cycle csr_we = 0, flush_o = 0.
- mtvec_q = 0x100, mstatus_q = 0x8, exc_valid = 1, exc_cause = 11, pc_in = 0x2004 -> writes 0x341 = 0x2004, 0x342 = 0xB, 0x300 = 0x1880; redirect_pc = 0x100 at T+4, redirect_valid high for one cycle.
- mtvec_q = 0x101, mstatus_q = 0x8, mie_q = 0x880, irq_ext = irq_timer = 1, pc_in = 0x40 -> mcause = 0x8000000B, redirect_pc = 0x12C.
- mstatus_q = 0x0, irq_timer = 1, mie_q = 0x80 -> no trap; mip_o = 0x80; pipe_csr_we pass-through of addr 0x305, data 0x200 in the same cycle.
- mstatus_q = 0x1880, mepc_q = 0x3000, mret_valid = 1 -> writes 0x300 = 0x1888; redirect_pc = 0x3000 at T+2.
- exc_valid, mret_valid and pipe_csr_we all high in the same cycle -> exception sequence runs, pipe write dropped; irq changes during busy states have no effect.

Source files
------------

// File: rtl/trap_controller.sv
// trap_controller
//   Sequences machine-mode trap entry (exceptions and interrupts) and trap
//   exit (mret). Owns the single CSR file write port: pipeline CSR writes pass
//   straight through while the controller is idle, and are replaced by the
//   controller's own mepc/mcause/mstatus writes while a sequence is running.
//   Drives pipeline flush/stall and a one-cycle PC redirect strobe.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   exc_valid, exc_cause        execute-stage exception and its code
//   mret_valid                  mret in execute stage
//   pc_in                       PC of the execute-stage instruction
//   irq_ext, irq_timer, irq_sw  level interrupt lines
//   mstatus_q, mie_q,
//   mtvec_q, mepc_q             current CSR values from the CSR file
//   pipe_csr_we/addr/wdata      pipeline CSR write request
//   csr_we/waddr/wdata          CSR file write port
//   mip_o                       pending-interrupt vector to the CSR file
//   flush_o, stall_o            flush IF/ID/EX, freeze PC and pipeline regs
//   redirect_valid, redirect_pc one-cycle PC redirect strobe and target
module trap_controller #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [3:0]        exc_cause,
    input  logic              mret_valid,
    input  logic [XLEN-1:0]   pc_in,
    input  logic              irq_ext,
    input  logic              irq_timer,
    input  logic              irq_sw,
    input  logic [XLEN-1:0]   mstatus_q,
    input  logic [XLEN-1:0]   mie_q,
    input  logic [XLEN-1:0]   mtvec_q,
    input  logic [XLEN-1:0]   mepc_q,
    input  logic              pipe_csr_we,
    input  logic [CSR_AW-1:0] pipe_csr_addr,
    input  logic [XLEN-1:0]   pipe_csr_wdata,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic [XLEN-1:0]   mip_o,
    output logic              flush_o,
    output logic              stall_o,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    localparam logic [CSR_AW-1:0] ADDR_MSTATUS = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] ADDR_MEPC    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] ADDR_MCAUSE  = CSR_AW'(12'h342);

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTAT,
        REDIR,
        R_MSTAT,
        R_REDIR
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:2]   pc_q;
    logic [3:0]        code_q, code_d;
    logic              intr_q, intr_d;
    logic [XLEN-1:0]   target_q, target_d;

    logic              irq_ext_en, irq_timer_en, irq_sw_en;
    logic              trap_take, mret_take;
    logic [XLEN-1:0]   base;
    logic [XLEN-1:0]   mcause;
    logic [XLEN-1:0]   mstat_trap, mstat_mret;

    // Bits of the inputs this block has no use for.
    logic unused_bits;
    assign unused_bits = ^{mie_q[XLEN-1:12], mie_q[10:8], mie_q[6:4], mie_q[2:0], pc_in[1:0]};

    always_comb begin
        mip_o     = '0;
        mip_o[11] = irq_ext;
        mip_o[7]  = irq_timer;
        mip_o[3]  = irq_sw;
    end

    assign irq_ext_en   = mstatus_q[3] & mie_q[11] & irq_ext;
    assign irq_timer_en = mstatus_q[3] & mie_q[7]  & irq_timer;
    assign irq_sw_en    = mstatus_q[3] & mie_q[3]  & irq_sw;

    // Event arbitration: exception > ext > sw > timer > mret, IDLE only.
    always_comb begin
        trap_take = 1'b0;
        mret_take = 1'b0;
        intr_d    = 1'b0;
        code_d    = exc_cause;
        if (state == IDLE) begin
            if (exc_valid) begin
                trap_take = 1'b1;
            end else if (irq_ext_en) begin
                trap_take = 1'b1;
                intr_d    = 1'b1;
                code_d    = 4'd11;
            end else if (irq_sw_en) begin
                trap_take = 1'b1;
                intr_d    = 1'b1;
                code_d    = 4'd3;
            end else if (irq_timer_en) begin
                trap_take = 1'b1;
                intr_d    = 1'b1;
                code_d    = 4'd7;
            end else if (mret_valid) begin
                mret_take = 1'b1;
            end
        end
    end

    // Vectored mode only offsets interrupts; the add wraps at XLEN bits.
    assign base = {mtvec_q[XLEN-1:2], 2'b00};
    always_comb begin
        target_d = base;
        if (mtvec_q[1:0] == 2'b01 && intr_d)
            target_d = base + XLEN'({code_d, 2'b00});
    end

    assign mcause = {intr_q, {(XLEN-5){1'b0}}, code_q};

    always_comb begin
        mstat_trap        = mstatus_q;
        mstat_trap[7]     = mstatus_q[3];
        mstat_trap[3]     = 1'b0;
        mstat_trap[12:11] = 2'b11;
        mstat_mret        = mstatus_q;
        mstat_mret[3]     = mstatus_q[7];
        mstat_mret[7]     = 1'b1;
        mstat_mret[12:11] = 2'b11;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= '0;
            code_q   <= '0;
            intr_q   <= 1'b0;
            target_q <= '0;
        end else begin
            state <= state_d;
            if (trap_take) begin
                pc_q     <= pc_in[XLEN-1:2];
                code_q   <= code_d;
                intr_q   <= intr_d;
                target_q <= target_d;
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        flush_o        = 1'b1;
        stall_o        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state)
            IDLE: begin
                if (trap_take) begin
                    state_d = W_MEPC;
                end else if (mret_take) begin
                    state_d = R_MSTAT;
                end else begin
                    flush_o   = 1'b0;
                    stall_o   = 1'b0;
                    csr_we    = pipe_csr_we;
                    csr_waddr = pipe_csr_addr;
                    csr_wdata = pipe_csr_wdata;
                end
            end
            W_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MEPC;
                csr_wdata = {pc_q, 2'b00};
                state_d   = W_MCAUSE;
            end
            W_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MCAUSE;
                csr_wdata = mcause;
                state_d   = W_MSTAT;
            end
            W_MSTAT: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mstat_trap;
                state_d   = REDIR;
            end
            REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
                state_d        = IDLE;
            end
            R_MSTAT: begin
                csr_we    = 1'b1;
                csr_waddr = ADDR_MSTATUS;
                csr_wdata = mstat_mret;
                state_d   = R_REDIR;
            end
            R_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_q;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller. Inputs change 1 time unit
// after the rising edge; outputs are checked 1 time unit later, well before
// the next edge.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        mret_valid;
    logic [31:0] pc_in;
    logic        irq_ext, irq_timer, irq_sw;
    logic [31:0] mstatus_q, mie_q, mtvec_q, mepc_q;
    logic        pipe_csr_we;
    logic [11:0] pipe_csr_addr;
    logic [31:0] pipe_csr_wdata;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] mip_o;
    logic        flush_o, stall_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    trap_controller #(.XLEN(32), .CSR_AW(12)) dut (
        .clk           (clk),
        .rst           (rst),
        .exc_valid     (exc_valid),
        .exc_cause     (exc_cause),
        .mret_valid    (mret_valid),
        .pc_in         (pc_in),
        .irq_ext       (irq_ext),
        .irq_timer     (irq_timer),
        .irq_sw        (irq_sw),
        .mstatus_q     (mstatus_q),
        .mie_q         (mie_q),
        .mtvec_q       (mtvec_q),
        .mepc_q        (mepc_q),
        .pipe_csr_we   (pipe_csr_we),
        .pipe_csr_addr (pipe_csr_addr),
        .pipe_csr_wdata(pipe_csr_wdata),
        .csr_we        (csr_we),
        .csr_waddr     (csr_waddr),
        .csr_wdata     (csr_wdata),
        .mip_o         (mip_o),
        .flush_o       (flush_o),
        .stall_o       (stall_o),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Checks the controller-owned write port in one go.
    task automatic check_wr(input string tag, input logic [11:0] addr, input logic [31:0] data);
        check({tag, ".we"},    32'(csr_we),    32'd1);
        check({tag, ".addr"},  32'(csr_waddr), 32'(addr));
        check({tag, ".data"},  csr_wdata,      data);
        check({tag, ".flush"}, 32'(flush_o),   32'd1);
    endtask

    initial begin
        rst = 1'b1;
        exc_valid = 0; exc_cause = 0; mret_valid = 0; pc_in = 0;
        irq_ext = 0; irq_timer = 0; irq_sw = 0;
        mstatus_q = 0; mie_q = 0; mtvec_q = 0; mepc_q = 0;
        pipe_csr_we = 0; pipe_csr_addr = 0; pipe_csr_wdata = 0;

        // ---- reset state
        tick(); tick();
        check("rst.csr_we",   32'(csr_we),         32'd0);
        check("rst.flush",    32'(flush_o),        32'd0);
        check("rst.stall",    32'(stall_o),        32'd0);
        check("rst.redir_v",  32'(redirect_valid), 32'd0);
        check("rst.redir_pc", redirect_pc,         32'h0);
        check("rst.mip",      mip_o,               32'h0);
        rst = 1'b0;
        tick();

        // ---- ecall with mret and a pipeline write in the same cycle
        mtvec_q = 32'h100; mstatus_q = 32'h8;
        exc_valid = 1; exc_cause = 4'd11; pc_in = 32'h2004; mret_valid = 1;
        pipe_csr_we = 1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'hDEAD;
        settle();
        check("exc.det.csr_we", 32'(csr_we),         32'd0);
        check("exc.det.flush",  32'(flush_o),        32'd1);
        check("exc.det.stall",  32'(stall_o),        32'd1);
        check("exc.det.redir",  32'(redirect_valid), 32'd0);
        tick();
        exc_valid = 0; mret_valid = 0; pipe_csr_we = 0;
        irq_ext = 1; mie_q = 32'h800;          // ignored while busy
        settle();
        check_wr("exc.mepc", 12'h341, 32'h2004);
        check("exc.mepc.stall", 32'(stall_o), 32'd1);
        tick();
        check_wr("exc.mcause", 12'h342, 32'hB);
        tick();
        check_wr("exc.mstat", 12'h300, 32'h1880);
        tick();
        irq_ext = 0; mstatus_q = 32'h1880;
        settle();
        check("exc.redir_v",  32'(redirect_valid), 32'd1);
        check("exc.redir_pc", redirect_pc,         32'h100);
        check("exc.redir_we", 32'(csr_we),         32'd0);
        tick();
        check("exc.post.redir_v", 32'(redirect_valid), 32'd0);
        check("exc.post.flush",   32'(flush_o),        32'd0);
        check("exc.post.stall",   32'(stall_o),        32'd0);

        // ---- external interrupt, vectored; timer also pending but lower priority
        mtvec_q = 32'h101; mstatus_q = 32'h8; mie_q = 32'h880;
        irq_ext = 1; irq_timer = 1; pc_in = 32'h42;
        settle();
        check("ext.det.mip",   mip_o,         32'h880);
        check("ext.det.flush", 32'(flush_o),  32'd1);
        tick();
        check_wr("ext.mepc", 12'h341, 32'h40);
        tick();
        check_wr("ext.mcause", 12'h342, 32'h8000000B);
        tick();
        check_wr("ext.mstat", 12'h300, 32'h1880);
        irq_ext = 0; irq_timer = 0;
        tick();
        mstatus_q = 32'h1880;
        settle();
        check("ext.redir_v",  32'(redirect_valid), 32'd1);
        check("ext.redir_pc", redirect_pc,         32'h12C);
        tick();
        check("ext.post.flush", 32'(flush_o), 32'd0);

        // ---- software beats timer; vectored offset 3*4
        mstatus_q = 32'h8; mie_q = 32'h88; irq_sw = 1; irq_timer = 1; pc_in = 32'h500;
        settle();
        check("sw.det.flush", 32'(flush_o), 32'd1);
        tick();
        irq_sw = 0; irq_timer = 0;
        tick();
        check_wr("sw.mcause", 12'h342, 32'h80000003);
        tick(); tick();
        mstatus_q = 32'h1880;
        settle();
        check("sw.redir_pc", redirect_pc, 32'h10C);
        tick();

        // ---- interrupts globally disabled: no trap, pipeline write passes
        mstatus_q = 32'h0; mie_q = 32'h80; irq_timer = 1;
        pipe_csr_we = 1; pipe_csr_addr = 12'h305; pipe_csr_wdata = 32'h200;
        settle();
        check("pass.mip",   mip_o,          32'h80);
        check("pass.we",    32'(csr_we),    32'd1);
        check("pass.addr",  32'(csr_waddr), 32'h305);
        check("pass.data",  csr_wdata,      32'h200);
        check("pass.flush", 32'(flush_o),   32'd0);
        tick();
        pipe_csr_we = 0; irq_timer = 0;
        settle();
        check("pass.next.flush", 32'(flush_o), 32'd0);
        check("pass.next.we",    32'(csr_we),  32'd0);

        // ---- mret
        mstatus_q = 32'h1880; mepc_q = 32'h3000; mret_valid = 1;
        settle();
        check("mret.det.flush", 32'(flush_o), 32'd1);
        check("mret.det.we",    32'(csr_we),  32'd0);
        tick();
        mret_valid = 0;
        settle();
        check_wr("mret.mstat", 12'h300, 32'h1888);
        tick();
        mstatus_q = 32'h1888; mtvec_q = 32'h100; mie_q = 32'h800; irq_ext = 1;
        settle();
        check("mret.redir_v",  32'(redirect_valid), 32'd1);
        check("mret.redir_pc", redirect_pc,         32'h3000);
        tick();
        // pending irq traps in the first IDLE cycle after R_REDIR
        settle();
        check("mret.irq.redir_v", 32'(redirect_valid), 32'd0);
        check("mret.irq.det",     32'(flush_o),        32'd1);
        tick();
        check("mret.irq.mepc.we", 32'(csr_we), 32'd1);
        tick();
        check_wr("mret.irq.mcause", 12'h342, 32'h8000000B);

        // ---- asynchronous reset during W_MCAUSE abandons the sequence
        rst = 1; irq_ext = 0; mstatus_q = 32'h0;
        settle();
        check("rstmid.we",    32'(csr_we),         32'd0);
        check("rstmid.flush", 32'(flush_o),        32'd0);
        check("rstmid.pc",    redirect_pc,         32'h0);
        tick();
        rst = 0;
        tick();
        check("rstmid.post.flush", 32'(flush_o),        32'd0);
        check("rstmid.post.redir", 32'(redirect_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
